md_unit: RTL and testbench

- Multiply/divide unit in the EX stage, directly downstream of the instruction decoder.
- Consumes the decoder's start, MDop, ifmsub, mthi, mtlo, regwritemd and mf strobes, plus the two forwarded GPR operands.
- Owns the HI/LO registers and holds busy for a fixed multi-cycle latency, so the hazard unit can stall dependent mf*/md instructions.
- Drives the mfhi/mflo read data back into the EX result mux.

---
 rtl/md_unit_pkg.sv | 21 ++
 rtl/md_arith.sv | 61 ++++++
 rtl/md_unit.sv | 104 ++++++++++
 tb/tb_md_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared encodings for the EX-stage multiply/divide unit.
//   md_op_e          : decoder MDop field (multu/mult/divu/div)
//   MF_LO / MF_HI    : decoder mf field selecting the HI/LO read
//   MULT_CYCLES_DEF  : default busy latency for mult/multu/msub
//   DIV_CYCLES_DEF   : default busy latency for div/divu
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b10,
    MD_DIVU  = 2'b01,
    MD_DIV   = 2'b11
  } md_op_e;

  localparam logic [1:0] MF_LO = 2'b01;
  localparam logic [1:0] MF_HI = 2'b10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational 64-bit result generator for md_unit.
// Ports:
//   a, b   : 32-bit operands (rs, rt)
//   op     : operation (multu/mult/divu/div)
//   msub   : with op=MD_MULT, subtract the signed product from hilo
//   hilo   : current {HI,LO}, used only by msub
//   result : {hi,lo}; for divides hi=remainder, lo=quotient
module md_arith
  import md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  input  logic        msub,
  input  logic [63:0] hilo,
  output logic [63:0] result
);

  logic [63:0]        prod_u;
  logic signed [63:0] prod_s;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [31:0]        q_m;
  logic [31:0]        r_m;

  // Signed divide works on magnitudes, then re-applies signs: the quotient
  // is negative when operand signs differ (truncation toward zero) and the
  // remainder follows the dividend. Divide by zero returns {A, all-ones}.
  always_comb begin
    prod_u = {32'b0, a} * {32'b0, b};
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mag_a  = a[31] ? (~a + 32'd1) : a;
    mag_b  = b[31] ? (~b + 32'd1) : b;
    q_u    = a / b;
    r_u    = a % b;
    q_m    = mag_a / mag_b;
    r_m    = mag_a % mag_b;
    result = '0;
    case (op)
      MD_MULTU: result = prod_u;
      MD_MULT:  result = msub ? (hilo - $unsigned(prod_s)) : $unsigned(prod_s);
      MD_DIVU: begin
        if (b == 32'd0) result = {a, 32'hFFFF_FFFF};
        else            result = {r_u, q_u};
      end
      MD_DIV: begin
        if (b == 32'd0)
          result = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          result = {32'd0, 32'h8000_0000};
        else
          result = {(a[31] ? (~r_m + 32'd1) : r_m),
                    ((a[31] ^ b[31]) ? (~q_m + 32'd1) : q_m)};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, reset (async, active-low)
//   A, B           : forwarded rs/rt operands
//   start, MDop    : launch an operation; ifmsub selects msub with MD_MULT
//   mthi, mtlo     : move A into HI/LO, qualified by regwritemd
//   mf             : read select for md_out (MF_LO / MF_HI)
//   clr            : flush the in-flight operation
//   busy           : operation in progress (hazard stall source)
//   md_out         : combinational HI/LO read data
//   HI, LO         : architectural HI/LO registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [1:0]  MDop,
  input  logic        ifmsub,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        regwritemd,
  input  logic [1:0]  mf,
  input  logic        clr,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_op_e           op;
  logic             is_div;
  logic [63:0]      arith_res;
  logic [63:0]      res;
  logic [CNT_W-1:0] cnt;

  assign op     = md_op_e'(MDop);
  assign is_div = (op == MD_DIVU) || (op == MD_DIV);

  // HI/LO are stable for the whole busy window, so computing msub against
  // them at launch gives the same answer as sampling them at completion.
  md_arith u_arith (
    .a      (A),
    .b      (B),
    .op     (op),
    .msub   (ifmsub),
    .hilo   ({HI, LO}),
    .result (arith_res)
  );

  // Priority: clr, then completion/countdown, then launch, then moves.
  // Being in the busy branch is what makes start and mthi/mtlo ignored
  // while busy; start beating a same-edge move falls out of the else-if.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI   <= '0;
      LO   <= '0;
      busy <= 1'b0;
      cnt  <= '0;
      res  <= '0;
    end else if (clr) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == CNT_ONE) begin
        HI   <= res[63:32];
        LO   <= res[31:0];
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end else if (start) begin
      res  <= arith_res;
      cnt  <= is_div ? DIV_LOAD : MULT_LOAD;
      busy <= 1'b1;
    end else if (regwritemd) begin
      if (mthi) HI <= A;
      if (mtlo) LO <= A;
    end
  end

  // No bypass of a completing result: this only ever shows the registers.
  always_comb begin
    md_out = '0;
    case (mf)
      MF_LO:   md_out = LO;
      MF_HI:   md_out = HI;
      default: md_out = '0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a behavioural model of
// the multiply/divide arithmetic built on 64-bit integer math.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  bit          clk_run = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        start, ifmsub, mthi, mtlo, regwritemd, clr;
  logic [1:0]  MDop, mf;
  logic        busy;
  logic [31:0] md_out, HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .start(start), .MDop(MDop),
    .ifmsub(ifmsub), .mthi(mthi), .mtlo(mtlo), .regwritemd(regwritemd),
    .mf(mf), .clr(clr), .busy(busy), .md_out(md_out), .HI(HI), .LO(LO)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference: {hi,lo} from plain integer arithmetic. SV signed division
  // already truncates toward zero with the dividend's remainder sign, and
  // doing it in 64 bits makes 0x80000000 / -1 wrap to the required value.
  function automatic logic [63:0] model(input logic [1:0] op, input logic ms,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] hilo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return ua * ub;
      2'b10: begin
        p = sa * sb;
        return ms ? hilo - p : p;
      end
      2'b01: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Called at a negedge: launches one op and returns how many following
  // negedges showed busy high (bounded so a stuck busy cannot hang).
  task automatic launch(input logic [1:0] op, input logic ms,
                        input logic [31:0] a, input logic [31:0] b, output int cyc);
    MDop = op; ifmsub = ms; A = a; B = b; start = 1'b1;
    cyc = 0;
    for (int i = 0; i < DIV_N + 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      ifmsub = 1'b0;
      if (busy) cyc++;
      else break;
    end
  endtask

  task automatic move(input logic h, input logic l, input logic [31:0] a);
    regwritemd = 1'b1; mthi = h; mtlo = l; A = a;
    @(negedge clk);
    regwritemd = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; A = '0; B = '0; start = 0; MDop = 0; ifmsub = 0;
    mthi = 0; mtlo = 0; regwritemd = 0; mf = 2'b01; clr = 0;
    #3 reset = 1'b0;
    #10;
    checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", LO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (md_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_mdout: got %h expected 0", md_out); end
    reset = 1'b1;
    #3 clk_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int cyc;
    launch(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (cyc !== MULT_N) begin errors++; $display("[TB] FAIL mult_busy: got %0d expected %0d", cyc, MULT_N); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffffe", LO); end
  endtask

  task automatic test_multu_msub;
    int cyc;
    launch(2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (HI !== 32'd1) begin errors++; $display("[TB] FAIL multu_hi: got %h expected 1", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_lo: got %h expected fffffffe", LO); end
    move(1'b1, 1'b0, 32'd0);
    move(1'b0, 1'b1, 32'd20);
    checks++; if (LO !== 32'd20) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected 14", LO); end
    launch(2'b10, 1'b1, 32'd3, 32'd4, cyc);
    checks++; if (cyc !== MULT_N) begin errors++; $display("[TB] FAIL msub_busy: got %0d expected %0d", cyc, MULT_N); end
    checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL msub_hi: got %h expected 0", HI); end
    checks++; if (LO !== 32'd8) begin errors++; $display("[TB] FAIL msub_lo: got %h expected 8", LO); end
  endtask

  task automatic test_div;
    int cyc;
    launch(2'b11, 1'b0, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc !== DIV_N) begin errors++; $display("[TB] FAIL div_busy: got %0d expected %0d", cyc, DIV_N); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected ffffffff", HI); end
    launch(2'b01, 1'b0, 32'd7, 32'd0, cyc);
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divz_lo: got %h expected ffffffff", LO); end
    checks++; if (HI !== 32'd7) begin errors++; $display("[TB] FAIL divz_hi: got %h expected 7", HI); end
    launch(2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("[TB] FAIL divovf_lo: got %h expected 80000000", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL divovf_hi: got %h expected 0", HI); end
  endtask

  task automatic test_ignored;
    int cyc;
    MDop = 2'b01; A = 32'd100; B = 32'd7; start = 1'b1;
    cyc = 0;
    for (int i = 1; i < DIV_N + 8; i++) begin
      @(negedge clk);
      start = 1'b0; regwritemd = 1'b0; mthi = 1'b0;
      if (i == 3) begin
        start = 1'b1; MDop = 2'b10; A = 32'h55; B = 32'd3;
        regwritemd = 1'b1; mthi = 1'b1;
      end
      if (busy) cyc++;
      else break;
    end
    start = 1'b0; regwritemd = 1'b0; mthi = 1'b0;
    checks++; if (cyc !== DIV_N) begin errors++; $display("[TB] FAIL ign_busy: got %0d expected %0d", cyc, DIV_N); end
    checks++; if (LO !== 32'd14) begin errors++; $display("[TB] FAIL ign_lo: got %h expected e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("[TB] FAIL ign_hi: got %h expected 2", HI); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_idle: got %b expected 0", busy); end
  endtask

  task automatic test_clr;
    int cyc;
    move(1'b1, 1'b1, 32'h1234);
    move(1'b0, 1'b1, 32'h5678);
    MDop = 2'b11; A = 32'd50; B = 32'd3; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_pre_busy: got %b expected 1", busy); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy: got %b expected 0", busy); end
    checks++; if (HI !== 32'h1234) begin errors++; $display("[TB] FAIL clr_hi: got %h expected 1234", HI); end
    checks++; if (LO !== 32'h5678) begin errors++; $display("[TB] FAIL clr_lo: got %h expected 5678", LO); end
    launch(2'b00, 1'b0, 32'd6, 32'd7, cyc);
    checks++; if (cyc !== MULT_N) begin errors++; $display("[TB] FAIL clr_next_busy: got %0d expected %0d", cyc, MULT_N); end
    checks++; if ({HI, LO} !== 64'd42) begin errors++; $display("[TB] FAIL clr_next_res: got %h expected 2a", {HI, LO}); end
  endtask

  task automatic test_mf;
    int cyc;
    move(1'b1, 1'b0, 32'h77);
    move(1'b0, 1'b1, 32'hCAFE_BABE);
    mf = 2'b01; #1;
    checks++; if (md_out !== 32'hCAFE_BABE) begin errors++; $display("[TB] FAIL mf_lo: got %h expected cafebabe", md_out); end
    mf = 2'b10; #1;
    checks++; if (md_out !== 32'h77) begin errors++; $display("[TB] FAIL mf_hi: got %h expected 77", md_out); end
    mf = 2'b00; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("[TB] FAIL mf_00: got %h expected 0", md_out); end
    mf = 2'b11; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("[TB] FAIL mf_11: got %h expected 0", md_out); end
    mf = 2'b10;
    @(negedge clk);
    MDop = 2'b00; A = 32'd9; B = 32'd9; start = 1'b1; regwritemd = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; regwritemd = 1'b0; mthi = 1'b0;
    checks++; if (md_out !== 32'h77) begin errors++; $display("[TB] FAIL samedge_hi: got %h expected 77", md_out); end
    cyc = 1;
    for (int i = 0; i < MULT_N + 8 && busy; i++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    checks++; if (cyc !== MULT_N) begin errors++; $display("[TB] FAIL samedge_busy: got %0d expected %0d", cyc, MULT_N); end
    checks++; if ({HI, LO} !== 64'd81) begin errors++; $display("[TB] FAIL samedge_res: got %h expected 51", {HI, LO}); end
  endtask

  task automatic test_random;
    int cyc;
    logic [1:0]  op;
    logic        ms;
    logic [31:0] a, b;
    logic [63:0] exp;
    exp_hi = $urandom;
    exp_lo = $urandom;
    move(1'b1, 1'b0, exp_hi);
    move(1'b0, 1'b1, exp_lo);
    for (int n = 0; n < 16; n++) begin
      op = 2'($urandom_range(0, 3));
      ms = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp = model(op, ms, a, b, {exp_hi, exp_lo});
      launch(op, ms, a, b, cyc);
      checks++; if (cyc !== (op[0] ? DIV_N : MULT_N)) begin errors++; $display("[TB] FAIL rnd_busy op=%b: got %0d expected %0d", op, cyc, op[0] ? DIV_N : MULT_N); end
      checks++; if ({HI, LO} !== exp) begin errors++; $display("[TB] FAIL rnd_res op=%b ms=%b a=%h b=%h: got %h expected %h", op, ms, a, b, {HI, LO}, exp); end
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu_msub;
    test_div;
    test_ignored;
    test_clr;
    test_mf;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
